// File: rtl/mantissa_unpack.sv
// mantissa_unpack: restores a truncated mantissa into the 64-bit working field
// and normalizes it so the leading one sits at bit 61.
//
// Optional feature: define MANTISSA_UNPACK_STICKY_EN to add the 'sticky' output,
// the OR of the input bits discarded by the valid-bit mask.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; captures mantissa_in and k_in
// MASK     | derive nbt from k, mask the field, load the working register
// NORM     | shift left one bit per cycle until bit 61 is set or field is 0
// COMPLETE | publish result registers and pulse done
module mantissa_unpack #(
  parameter int NBT_BASE = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] mantissa_in,
  input  logic [5:0]  k_in,
  output logic [63:0] mantissa_out,
  output logic [5:0]  norm_shift,
  output logic        zero,
  output logic        busy,
  output logic        done
`ifdef MANTISSA_UNPACK_STICKY_EN
  ,
  output logic        sticky
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MASK     = 2'd1,
    NORM     = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0] mant_r;
  logic [5:0]  k_r;
  logic [63:0] work;
  logic [5:0]  shift_cnt;
  logic        zero_r;
`ifdef MANTISSA_UNPACK_STICKY_EN
  logic        sticky_r;
`endif

  logic signed [6:0] k_ext;
  logic signed [6:0] abs_k;
  logic signed [6:0] nbt_raw;
  logic [5:0]        nbt;
  logic [31:0]       mask;

  // Valid-bit count from the captured scale, clamped to 0..32, and its MSB mask.
  // |k| is formed in 7 bits so k = -32 does not wrap.
  always_comb begin
    k_ext   = {k_r[5], k_r};
    abs_k   = k_ext[6] ? -k_ext : k_ext;
    nbt_raw = k_ext[6] ? (7'(NBT_BASE + 1) - abs_k) : (7'(NBT_BASE) - k_ext);
    nbt     = 6'd0;
    if (nbt_raw[6]) begin
      nbt = 6'd0;
    end else if (nbt_raw > 7'sd32) begin
      nbt = 6'd32;
    end else begin
      nbt = nbt_raw[5:0];
    end
    mask = ~(32'hFFFF_FFFF >> nbt);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and busy flag.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:     if (start) state_nxt = MASK;
      MASK:     state_nxt = NORM;
      NORM:     if ((work == 64'd0) || work[61]) state_nxt = COMPLETE;
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Capture, masking, normalization shifts and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_r       <= '0;
      k_r          <= '0;
      work         <= '0;
      shift_cnt    <= '0;
      zero_r       <= 1'b0;
      mantissa_out <= '0;
      norm_shift   <= '0;
      zero         <= 1'b0;
      done         <= 1'b0;
`ifdef MANTISSA_UNPACK_STICKY_EN
      sticky_r     <= 1'b0;
      sticky       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mant_r <= mantissa_in;
            k_r    <= k_in;
          end
        end
        MASK: begin
          work      <= {2'b00, mant_r & mask, 30'b0};
          shift_cnt <= '0;
          zero_r    <= 1'b0;
`ifdef MANTISSA_UNPACK_STICKY_EN
          sticky_r  <= |(mant_r & ~mask);
`endif
        end
        NORM: begin
          if (work == 64'd0) begin
            zero_r <= 1'b1;
          end else if (!work[61]) begin
            work      <= work << 1;
            shift_cnt <= shift_cnt + 6'd1;
          end
        end
        COMPLETE: begin
          mantissa_out <= work;
          norm_shift   <= shift_cnt;
          zero         <= zero_r;
          done         <= 1'b1;
`ifdef MANTISSA_UNPACK_STICKY_EN
          sticky       <= sticky_r;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
